// File: rtl/bounce_multi.sv
// bounce_multi: per-channel run-length debouncer with registered rise/fall strobes and a settled flag.
// Each channel only updates its output after THRESH consecutive equal enabled samples.
module bounce_multi #(
    parameter int CHANNELS = 4,
    parameter int THRESH   = 8,
    parameter bit INIT     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [CHANNELS-1:0] line,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] settled
);
    localparam int CNT_W = $clog2(THRESH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(THRESH);

    if (THRESH < 1 || THRESH > 255) begin : g_bad_thresh
        $error("bounce_multi: THRESH must be in 1..255");
    end

    genvar c;
    for (c = 0; c < CHANNELS; c++) begin : g_ch
        logic             val, deb, r, f, s, restart, hit;
        logic [CNT_W-1:0] cnt, n;
        assign restart = (cnt == '0) || (line[c] != val);
        // n is the run length this sample produces; it saturates so a long run keeps hitting
        assign n       = restart ? CNT_W'(1) : (cnt == FULL ? cnt : cnt + CNT_W'(1));
        assign hit     = (n == FULL);
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val <= INIT;
                cnt <= '0;
                deb <= INIT;
                r   <= 1'b0;
                f   <= 1'b0;
                s   <= 1'b0;
            end else if (enable) begin
                val <= line[c];
                cnt <= n;
                r   <= hit && line[c] && !deb;
                f   <= hit && !line[c] && deb;
                if (hit) begin
                    deb <= line[c];
                    s   <= 1'b1;
                end
            end else begin
                cnt <= '0;
                r   <= 1'b0;
                f   <= 1'b0;
                s   <= 1'b0;
            end
        end
        assign debounced[c] = deb;
        assign rise[c]      = r;
        assign fall[c]      = f;
        assign settled[c]   = s;
    end
endmodule

// File: tb/tb_bounce_multi.sv
// tb_bounce_multi: drives a THRESH=8 and a THRESH=1 instance side by side; a behavioural
// run-length model pushes expected outputs to a queue that each test pops after the edge.
module tb_bounce_multi;
    logic       clk = 1'b0, rst = 1'b1, en8 = 1'b0, en1 = 1'b0;
    logic [3:0] ln8 = '0, ln1 = '0;
    logic [3:0] deb8, rise8, fall8, set8, deb1, rise1, fall1, set1;
    int         n_chk = 0, n_fail = 0;
    logic [31:0] sb[$];
    int         len[2][4];
    bit         mval[2][4], mdeb[2][4], mset[2][4];

    always #5 clk = ~clk;

    bounce_multi #(.CHANNELS(4), .THRESH(8), .INIT(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(en8), .line(ln8),
        .debounced(deb8), .rise(rise8), .fall(fall8), .settled(set8)
    );

    bounce_multi #(.CHANNELS(4), .THRESH(1), .INIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .enable(en1), .line(ln1),
        .debounced(deb1), .rise(rise1), .fall(fall1), .settled(set1)
    );

    function automatic logic [31:0] got();
        return {deb8, rise8, fall8, set8, deb1, rise1, fall1, set1};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int ch = 0; ch < 4; ch++) begin
                len[k][ch] = 0; mval[k][ch] = 0; mdeb[k][ch] = 0; mset[k][ch] = 0;
            end
    endtask

    task automatic model_step(input int k, input int th, input bit en, input logic [3:0] ln,
                              output logic [15:0] o);
        logic [3:0] d, r, f, s;
        r = '0; f = '0;
        for (int ch = 0; ch < 4; ch++) begin
            if (!en) begin
                len[k][ch] = 0; mset[k][ch] = 0;
            end else begin
                if (len[k][ch] > 0 && ln[ch] == mval[k][ch]) len[k][ch]++;
                else begin len[k][ch] = 1; mval[k][ch] = ln[ch]; end
                if (len[k][ch] >= th) begin
                    r[ch] = ln[ch] & ~mdeb[k][ch];
                    f[ch] = ~ln[ch] & mdeb[k][ch];
                    mdeb[k][ch] = ln[ch];
                    mset[k][ch] = 1;
                end
            end
            d[ch] = mdeb[k][ch]; s[ch] = mset[k][ch];
        end
        o = {d, r, f, s};
    endtask

    task automatic step(input bit e8, input logic [3:0] l8, input bit e1, input logic [3:0] l1);
        logic [15:0] a, b;
        en8 = e8; ln8 = l8; en1 = e1; ln1 = l1;
        model_step(0, 8, e8, l8, a);
        model_step(1, 1, e1, l1, b);
        sb.push_back({a, b});
        @(posedge clk); #1;
    endtask

    task automatic hard_reset();
        rst = 1'b1; en8 = 0; en1 = 0; ln8 = '0; ln1 = '0;
        model_reset();
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        hard_reset();
        n_chk++;
        if (got() !== 32'h0) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got(), 32'h0); end
        for (int i = 0; i < 15; i++) begin
            step(1, i < 8 ? 4'b0011 : 4'b1111, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL reset_pre: got %h expected %h", got(), e); end
        end
        #3 rst = 1'b1;
        #1 n_chk++;
        if (got() !== 32'h0) begin n_fail++; $display("FAIL async_rst: got %h expected %h", got(), 32'h0); end
        model_reset();
        #1 rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1, 4'b1111, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL reset_post: got %h expected %h", got(), e); end
            if (i == 1) begin
                n_chk++;
                if (deb8 !== 4'b0000) begin n_fail++; $display("FAIL run_discard: got %b expected %b", deb8, 4'b0000); end
            end
        end
        n_chk++;
        if ({deb8, rise8} !== 8'hff) begin n_fail++; $display("FAIL reset_rerun: got %h expected %h", {deb8, rise8}, 8'hff); end
    endtask

    task automatic test_rise_hold();
        logic [31:0] e;
        hard_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1, 4'b0001, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL rise_hold: got %h expected %h", got(), e); end
            if (i == 7) begin
                n_chk++;
                if (deb8[0] !== 1'b0) begin n_fail++; $display("FAIL rise_early: got %b expected 0", deb8[0]); end
            end
            if (i == 8) begin
                n_chk++;
                if ({deb8[0], rise8[0], set8[0]} !== 3'b111) begin n_fail++; $display("FAIL rise_8th: got %b expected 111", {deb8[0], rise8[0], set8[0]}); end
            end
            if (i == 9) begin
                n_chk++;
                if ({deb8[0], rise8[0], set8[0]} !== 3'b101) begin n_fail++; $display("FAIL rise_strobe_once: got %b expected 101", {deb8[0], rise8[0], set8[0]}); end
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] e;
        int rises = 0;
        hard_reset();
        for (int i = 1; i <= 18; i++) begin
            step(1, (i == 8) ? 4'b0000 : 4'b0010, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL glitch: got %h expected %h", got(), e); end
            rises += int'(rise8[1]);
            if (i == 15) begin
                n_chk++;
                if (deb8[1] !== 1'b0) begin n_fail++; $display("FAIL glitch_early: got %b expected 0", deb8[1]); end
            end
            if (i == 16) begin
                n_chk++;
                if ({deb8[1], rise8[1]} !== 2'b11) begin n_fail++; $display("FAIL glitch_16th: got %b expected 11", {deb8[1], rise8[1]}); end
            end
        end
        n_chk++;
        if (rises != 1) begin n_fail++; $display("FAIL glitch_rise_count: got %0d expected 1", rises); end
    endtask

    task automatic test_enable_gap();
        logic [31:0] e;
        hard_reset();
        for (int i = 1; i <= 24; i++) begin
            if (i <= 8) step(1, 4'b0100, 0, 4'h0);
            else if (i <= 13) step(1, 4'b0101, 0, 4'h0);
            else if (i <= 16) step(0, 4'b0101, 0, 4'h0);
            else step(1, 4'b0101, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL enable_gap: got %h expected %h", got(), e); end
            if (i == 16) begin
                n_chk++;
                if ({deb8, set8} !== 8'h40) begin n_fail++; $display("FAIL gap_hold: got %h expected %h", {deb8, set8}, 8'h40); end
            end
            if (i == 23) begin
                n_chk++;
                if (deb8 !== 4'b0100) begin n_fail++; $display("FAIL gap_restart: got %b expected %b", deb8, 4'b0100); end
            end
        end
        n_chk++;
        if ({deb8, rise8} !== 8'h51) begin n_fail++; $display("FAIL gap_rise: got %h expected %h", {deb8, rise8}, 8'h51); end
    endtask

    task automatic test_multi();
        logic [31:0] e;
        hard_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1, i <= 8 ? 4'b0101 : 4'b1010, 0, 4'h0);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL multi: got %h expected %h", got(), e); end
        end
        n_chk++;
        if ({deb8, rise8, fall8} !== 12'haa5) begin n_fail++; $display("FAIL multi_edge: got %h expected %h", {deb8, rise8, fall8}, 12'haa5); end
    endtask

    task automatic test_thresh1();
        logic [31:0] e;
        logic [3:0]  l, prev;
        hard_reset();
        prev = '0;
        for (int i = 0; i < 24; i++) begin
            l = 4'($urandom);
            step(0, 4'h0, 1, l);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL thresh1: got %h expected %h", got(), e); end
            n_chk++;
            if ({deb1, rise1, fall1, set1} !== {l, l & ~prev, ~l & prev, 4'hf}) begin
                n_fail++;
                $display("FAIL thresh1_track: got %h expected %h", {deb1, rise1, fall1, set1}, {l, l & ~prev, ~l & prev, 4'hf});
            end
            prev = l;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        logic [3:0]  a, b;
        bit          ea, eb;
        hard_reset();
        a = '0; b = '0;
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 11) == 0) a[ch] = ~a[ch];
                if ($urandom_range(0, 2) == 0) b[ch] = ~b[ch];
            end
            ea = $urandom_range(0, 24) != 0;
            eb = $urandom_range(0, 5) != 0;
            step(ea, a, eb, b);
            e = sb.pop_front(); n_chk++;
            if (got() !== e) begin n_fail++; $display("FAIL back_to_back: cycle %0d got %h expected %h", i, got(), e); end
            n_chk++;
            if (((rise8 & fall8) | (rise1 & fall1)) !== 4'h0) begin
                n_fail++;
                $display("FAIL rise_fall_excl: got %b expected 0000", (rise8 & fall8) | (rise1 & fall1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_hold();
        test_glitch();
        test_enable_gap();
        test_multi();
        test_thresh1();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
